// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL network lock monitors: FSM states and the
// window/hysteresis defaults used by every node instance.
package adpll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_LOST
    } mon_state_e;

    localparam int unsigned DEF_WINDOW_REFS    = 16;
    localparam int unsigned DEF_TOL            = 1;
    localparam int unsigned DEF_LOCK_WINDOWS   = 4;
    localparam int unsigned DEF_UNLOCK_WINDOWS = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus a registered rising-edge pulse; input edge to
// pulse is three fabric cycles.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic [2:0] sync_q;
    logic       rise_q;

    // Flops reset high so a level already high at reset release is not an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
            rise_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/adpll_lock_monitor.sv
// Per-node lock monitor: counts div8 edges over a window of reference edges,
// reports the signed frequency error and keeps a hysteretic lock flag.
module adpll_lock_monitor
    import adpll_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = 12,
    parameter int unsigned WINDOW_REFS    = DEF_WINDOW_REFS,
    parameter int unsigned TOL            = DEF_TOL,
    parameter int unsigned LOCK_WINDOWS   = DEF_LOCK_WINDOWS,
    parameter int unsigned UNLOCK_WINDOWS = DEF_UNLOCK_WINDOWS,
    parameter int unsigned TIMEOUT_WIDTH  = 16
) (
    input  logic                 fpga_clk_i,
    input  logic                 rst_pbn_i,
    input  logic                 enable_i,
    input  logic                 ref_i,
    input  logic                 gen_i,
    output logic                 locked_o,
    output logic                 valid_o,
    output logic [CNT_WIDTH:0]   error_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 ref_lost_o
);

    localparam int unsigned CW = CNT_WIDTH;
    localparam int unsigned EW = CNT_WIDTH + 1;
    localparam int unsigned TW = TIMEOUT_WIDTH;
    localparam int unsigned GW = $clog2(LOCK_WINDOWS + 1);
    localparam int unsigned BW = $clog2(UNLOCK_WINDOWS + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [TW-1:0] TMO_MAX = '1;

    logic ref_rise, gen_rise;

    sync_edge_detect u_ref_sync (
        .clk_i  (fpga_clk_i),
        .rst_ni (rst_pbn_i),
        .d_i    (ref_i),
        .rise_o (ref_rise)
    );

    sync_edge_detect u_gen_sync (
        .clk_i  (fpga_clk_i),
        .rst_ni (rst_pbn_i),
        .d_i    (gen_i),
        .rise_o (gen_rise)
    );

    mon_state_e    state_q,   state_d;
    logic [CW-1:0] gen_cnt_q, gen_cnt_d;
    logic [CW-1:0] ref_cnt_q, ref_cnt_d;
    logic [TW-1:0] tmo_q,     tmo_d;
    logic [GW-1:0] good_q,    good_d;
    logic [BW-1:0] bad_q,     bad_d;
    logic          locked_q,  locked_d;
    logic          valid_q,   valid_d;
    logic [EW-1:0] error_q,   error_d;
    logic [CW-1:0] count_q,   count_d;
    logic          lost_q,    lost_d;

    // Window result including a gen edge coincident with the closing ref edge.
    logic [CW-1:0] gen_sat;
    logic [EW-1:0] win_err;
    logic [EW-1:0] err_mag;
    logic          in_tol;

    assign gen_sat = (gen_rise && gen_cnt_q != CNT_MAX) ? gen_cnt_q + CW'(1) : gen_cnt_q;
    assign win_err = {1'b0, gen_sat} - EW'(WINDOW_REFS);
    assign err_mag = win_err[EW-1] ? -win_err : win_err;
    assign in_tol  = (err_mag <= EW'(TOL));

    always_comb begin
        state_d   = state_q;
        gen_cnt_d = gen_cnt_q;
        ref_cnt_d = ref_cnt_q;
        tmo_d     = tmo_q;
        good_d    = good_q;
        bad_d     = bad_q;
        locked_d  = locked_q;
        valid_d   = 1'b0;
        error_d   = error_q;
        count_d   = count_q;
        lost_d    = lost_q;

        unique case (state_q)
            ST_IDLE: state_d = ST_ARM;
            ST_ARM: begin
                if (ref_rise) begin
                    state_d   = ST_MEASURE;
                    gen_cnt_d = '0;
                    ref_cnt_d = '0;
                    tmo_d     = TW'(1);
                end
            end
            ST_MEASURE: begin
                gen_cnt_d = gen_sat;
                tmo_d     = ref_rise ? TW'(1) : tmo_q + TW'(1);
                if (ref_rise) begin
                    if (ref_cnt_q == CW'(WINDOW_REFS - 1)) begin
                        ref_cnt_d = '0;
                        gen_cnt_d = '0;
                        valid_d   = 1'b1;
                        count_d   = gen_sat;
                        error_d   = win_err;
                        if (in_tol) begin
                            bad_d = '0;
                            if (good_q != GW'(LOCK_WINDOWS)) good_d = good_q + GW'(1);
                            if (good_d == GW'(LOCK_WINDOWS)) locked_d = 1'b1;
                        end else begin
                            good_d = '0;
                            if (bad_q != BW'(UNLOCK_WINDOWS)) bad_d = bad_q + BW'(1);
                            if (bad_d == BW'(UNLOCK_WINDOWS)) locked_d = 1'b0;
                        end
                    end else begin
                        ref_cnt_d = ref_cnt_q + CW'(1);
                    end
                end else if (tmo_q == TMO_MAX - TW'(1)) begin
                    // Counter would reach its maximum this cycle.
                    state_d  = ST_LOST;
                    lost_d   = 1'b1;
                    locked_d = 1'b0;
                    good_d   = '0;
                    bad_d    = '0;
                end
            end
            ST_LOST: begin
                if (ref_rise) begin
                    state_d = ST_ARM;
                    lost_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable_i) begin
            state_d   = ST_IDLE;
            gen_cnt_d = '0;
            ref_cnt_d = '0;
            tmo_d     = '0;
            good_d    = '0;
            bad_d     = '0;
            locked_d  = 1'b0;
            valid_d   = 1'b0;
            error_d   = '0;
            count_d   = '0;
            lost_d    = 1'b0;
        end
    end

    always_ff @(posedge fpga_clk_i or negedge rst_pbn_i) begin
        if (!rst_pbn_i) begin
            state_q   <= ST_IDLE;
            gen_cnt_q <= '0;
            ref_cnt_q <= '0;
            tmo_q     <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            locked_q  <= 1'b0;
            valid_q   <= 1'b0;
            error_q   <= '0;
            count_q   <= '0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gen_cnt_q <= gen_cnt_d;
            ref_cnt_q <= ref_cnt_d;
            tmo_q     <= tmo_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            locked_q  <= locked_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            count_q   <= count_d;
            lost_q    <= lost_d;
        end
    end

    assign locked_o   = locked_q;
    assign valid_o    = valid_q;
    assign error_o    = error_q;
    assign count_o    = count_q;
    assign ref_lost_o = lost_q;

endmodule

// File: tb/tb_adpll_lock_monitor.sv
// Directed self-checking bench for adpll_lock_monitor with default parameters.
module tb_adpll_lock_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        ref_in;
    logic        gen_in;
    logic        locked;
    logic        valid;
    logic [12:0] error;
    logic [11:0] count;
    logic        lost;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int ref_per = 40, gen_per = 40, ref_ph = 0, gen_ph = 0, ref_last = 0;
    bit ref_run = 1'b0, gen_run = 1'b0;
    logic nv_ref, nv_gen;

    adpll_lock_monitor dut (
        .fpga_clk_i (clk),
        .rst_pbn_i  (rst_n),
        .enable_i   (enable),
        .ref_i      (ref_in),
        .gen_i      (gen_in),
        .locked_o   (locked),
        .valid_o    (valid),
        .error_o    (error),
        .count_o    (count),
        .ref_lost_o (lost)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Square-wave sources stepped once per fabric cycle, 2 ns after the edge.
    initial begin
        ref_in = 1'b0;
        gen_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ref_run) begin
                if (ref_ph >= ref_per) ref_ph = 0;
                nv_ref = (ref_ph < ref_per / 2);
                if (nv_ref && !ref_in) ref_last = cyc;
                ref_in = nv_ref;
                ref_ph = ref_ph + 1;
            end else begin
                ref_in = 1'b0;
            end
            if (gen_run) begin
                if (gen_ph >= gen_per) gen_ph = 0;
                nv_gen = (gen_ph < gen_per / 2);
                gen_in = nv_gen;
                gen_ph = gen_ph + 1;
            end else begin
                gen_in = 1'b0;
            end
        end
    end

    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            got = (valid === 1'b1);
        end
    endtask

    task automatic restart(input int rp, input int gp, input int goff);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ref_per = rp;
        gen_per = gp;
        ref_ph  = 0;
        gen_ph  = goff;
        ref_run = 1'b1;
        gen_run = 1'b1;
        enable  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({locked, valid, error, count, lost} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=0", {locked, valid, error, count, lost});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({locked, valid, error, count, lost} !== 28'd0) begin
            n_err++;
            $display("FAIL disabled_outputs got=%h exp=0", {locked, valid, error, count, lost});
        end
    endtask

    task automatic test_matched();
        bit got;
        int last_c;
        logic exp_l;
        restart(40, 40, 20);
        for (int k = 1; k <= 5; k++) begin
            wait_valid(800, got);
            exp_l = (k >= 4);
            n_cmp++;
            if (!got || count !== 12'd16) begin
                n_err++;
                $display("FAIL matched_count[%0d] got=%0d exp=16 seen=%0b", k, count, got);
            end
            n_cmp++;
            if (error !== 13'd0) begin
                n_err++;
                $display("FAIL matched_error[%0d] got=%h exp=0", k, error);
            end
            n_cmp++;
            if (locked !== exp_l) begin
                n_err++;
                $display("FAIL matched_locked[%0d] got=%b exp=%b", k, locked, exp_l);
            end
            if (k > 1) begin
                n_cmp++;
                if (cyc - last_c != 640) begin
                    n_err++;
                    $display("FAIL matched_interval[%0d] got=%0d exp=640", k, cyc - last_c);
                end
            end
            last_c = cyc;
        end
    endtask

    task automatic test_ref_loss();
        bit   got;
        int   p, old;
        logic prev_l;
        ref_run = 1'b0;
        p       = ref_last;
        prev_l  = locked;
        got     = 1'b0;
        for (int i = 0; i < 70000 && !got; i++) begin
            @(negedge clk);
            if (lost === 1'b1) got = 1'b1;
            else prev_l = locked;
        end
        n_cmp++;
        if (!got || cyc != p + 65538) begin
            n_err++;
            $display("FAIL ref_loss_time got=%0d exp=65538 seen=%0b", cyc - p, got);
        end
        n_cmp++;
        if (prev_l !== 1'b1) begin
            n_err++;
            $display("FAIL ref_loss_locked_before got=%b exp=1", prev_l);
        end
        n_cmp++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL ref_loss_locked_after got=%b exp=0", locked);
        end
        // Restart the reference and track the LOST -> ARM -> MEASURE sequence.
        old     = ref_last;
        ref_ph  = 0;
        ref_run = 1'b1;
        for (int i = 0; i < 5 && ref_last == old; i++) @(negedge clk);
        p = ref_last;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (lost !== 1'b1) begin
            n_err++;
            $display("FAIL ref_restart_lost_held got=%b exp=1", lost);
        end
        @(negedge clk);
        n_cmp++;
        if (lost !== 1'b0) begin
            n_err++;
            $display("FAIL ref_restart_lost_clear got=%b exp=0", lost);
        end
        wait_valid(800, got);
        n_cmp++;
        if (!got || cyc != p + 684) begin
            n_err++;
            $display("FAIL ref_restart_first_valid got=%0d exp=684 seen=%0b", cyc - p, got);
        end
        n_cmp++;
        if (count !== 12'd16 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL ref_restart_result got=%0d/%b exp=16/0", count, locked);
        end
    endtask

    task automatic test_fast_gen();
        bit   got;
        logic exp_l;
        restart(40, 38, 20);
        for (int k = 1; k <= 4; k++) begin
            wait_valid(800, got);
            exp_l = (k == 4);
            n_cmp++;
            if (!got || !(count === 12'd16 || count === 12'd17)) begin
                n_err++;
                $display("FAIL fast_count[%0d] got=%0d exp=16..17 seen=%0b", k, count, got);
            end
            n_cmp++;
            if (!(error === 13'd0 || error === 13'd1)) begin
                n_err++;
                $display("FAIL fast_error[%0d] got=%h exp=0..1", k, error);
            end
            n_cmp++;
            if (locked !== exp_l) begin
                n_err++;
                $display("FAIL fast_locked[%0d] got=%b exp=%b", k, locked, exp_l);
            end
        end
        gen_per = 30;
        for (int k = 1; k <= 2; k++) begin
            wait_valid(800, got);
            exp_l = (k == 1);
            n_cmp++;
            if (!got || $isunknown(count) || count < 12'd20 || count > 12'd23) begin
                n_err++;
                $display("FAIL fast30_count[%0d] got=%0d exp=20..23 seen=%0b", k, count, got);
            end
            n_cmp++;
            if ($isunknown(error) || error < 13'd4 || error > 13'd7) begin
                n_err++;
                $display("FAIL fast30_error[%0d] got=%h exp=4..7", k, error);
            end
            n_cmp++;
            if (locked !== exp_l) begin
                n_err++;
                $display("FAIL fast30_locked[%0d] got=%b exp=%b", k, locked, exp_l);
            end
        end
    endtask

    task automatic test_gen_stop();
        bit   got;
        logic exp_l;
        restart(40, 40, 20);
        repeat (4) wait_valid(800, got);
        n_cmp++;
        if (!got || locked !== 1'b1) begin
            n_err++;
            $display("FAIL stop_prelock got=%b exp=1 seen=%0b", locked, got);
        end
        gen_run = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            wait_valid(800, got);
            exp_l = (k == 1);
            n_cmp++;
            if (!got || count !== 12'd0) begin
                n_err++;
                $display("FAIL stop_count[%0d] got=%0d exp=0 seen=%0b", k, count, got);
            end
            n_cmp++;
            if (error !== 13'h1FF0) begin
                n_err++;
                $display("FAIL stop_error[%0d] got=%h exp=1ff0", k, error);
            end
            n_cmp++;
            if (locked !== exp_l) begin
                n_err++;
                $display("FAIL stop_locked[%0d] got=%b exp=%b", k, locked, exp_l);
            end
        end
    endtask

    task automatic test_coincident();
        bit got;
        restart(40, 40, 0);
        for (int k = 1; k <= 2; k++) begin
            wait_valid(800, got);
            n_cmp++;
            if (!got || count !== 12'd16) begin
                n_err++;
                $display("FAIL coincident_count[%0d] got=%0d exp=16 seen=%0b", k, count, got);
            end
            n_cmp++;
            if (error !== 13'd0) begin
                n_err++;
                $display("FAIL coincident_error[%0d] got=%h exp=0", k, error);
            end
        end
    endtask

    task automatic test_reset_enable();
        bit got;
        int r;
        restart(40, 40, 20);
        wait_valid(800, got);
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({locked, valid, error, count, lost} !== 28'd0) begin
            n_err++;
            $display("FAIL midreset_outputs got=%h exp=0", {locked, valid, error, count, lost});
        end
        rst_n = 1'b1;
        r     = cyc;
        wait_valid(800, got);
        n_cmp++;
        if (!got || cyc - r < 643 || cyc - r > 685) begin
            n_err++;
            $display("FAIL midreset_first_valid got=%0d exp=643..685 seen=%0b", cyc - r, got);
        end
        n_cmp++;
        if (count !== 12'd16) begin
            n_err++;
            $display("FAIL midreset_count got=%0d exp=16", count);
        end
        repeat (300) @(negedge clk);
        enable = 1'b0;
        r      = cyc;
        @(negedge clk);
        n_cmp++;
        if ({locked, valid, error, count, lost} !== 28'd0) begin
            n_err++;
            $display("FAIL disable_outputs got=%h exp=0", {locked, valid, error, count, lost});
        end
        enable = 1'b1;
        wait_valid(800, got);
        n_cmp++;
        if (!got || cyc - r < 643 || cyc - r > 685) begin
            n_err++;
            $display("FAIL disable_first_valid got=%0d exp=643..685 seen=%0b", cyc - r, got);
        end
        n_cmp++;
        if (count !== 12'd16) begin
            n_err++;
            $display("FAIL disable_count got=%0d exp=16", count);
        end
    endtask

    initial begin
        test_reset();
        test_matched();
        test_ref_loss();
        test_fast_gen();
        test_gen_stop();
        test_coincident();
        test_reset_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
